// File: rtl/lfsr_rand.sv
// rtl/lfsr_rand.sv - Fibonacci LFSR random source with unbiased rejection-sampling draw engine
module lfsr_rand #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] TAPS      = 16'h9C00,
  parameter logic [WIDTH-1:0] SEED      = 16'hFFFF,
  parameter int               OUT_W     = 4,
  parameter int               MAX_TRIES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             free_run,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             req,
  input  logic [OUT_W-1:0] range,
  output logic             rdy,
  output logic             valid,
  output logic [OUT_W-1:0] value,
  output logic             fallback,
  output logic [WIDTH-1:0] lfsr_q
);

  localparam int TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TW-1:0] LAST_TRY = TW'(MAX_TRIES - 1);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  state_t           state_q;
  logic [TW-1:0]    tries_q;
  logic [OUT_W:0]   range_q;
  logic [OUT_W-1:0] value_q;
  logic             fallback_q;

  logic [WIDTH-1:0] lfsr_shift;
  logic [WIDTH-1:0] lfsr_d;
  logic             shift_en;
  logic [OUT_W-1:0] candidate;
  logic [OUT_W:0]   range_ext;

  // Range 0 means the full 2^OUT_W span, so the latched bound carries one extra bit.
  assign range_ext  = (range == '0) ? {1'b1, {OUT_W{1'b0}}} : {1'b0, range};
  assign lfsr_shift = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
  assign shift_en   = (state_q == DRAW) || free_run;
  // The candidate is whatever the LFSR is about to become, including a seed load.
  assign candidate  = lfsr_d[OUT_W-1:0];

  assign rdy      = (state_q == IDLE);
  assign valid    = (state_q == DONE);
  assign value    = value_q;
  assign fallback = fallback_q;

  // Next LFSR state: seed load beats lock-up recovery, which beats a normal shift.
  always_comb begin
    lfsr_d = lfsr_q;
    if (seed_load) begin
      lfsr_d = (seed_in == '0) ? SEED : seed_in;
    end else if (lfsr_q == '0) begin
      lfsr_d = SEED;
    end else if (shift_en) begin
      lfsr_d = lfsr_shift;
    end
  end

  // LFSR register plus the IDLE/DRAW/DONE draw engine with registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q     <= SEED;
      state_q    <= IDLE;
      tries_q    <= '0;
      range_q    <= '0;
      value_q    <= '0;
      fallback_q <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      case (state_q)
        IDLE: begin
          if (req) begin
            range_q <= range_ext;
            tries_q <= '0;
            state_q <= DRAW;
          end
        end
        DRAW: begin
          if ({1'b0, candidate} < range_q) begin
            value_q    <= candidate;
            fallback_q <= 1'b0;
            state_q    <= DONE;
          end else if (tries_q == LAST_TRY) begin
            value_q    <= '0;
            fallback_q <= 1'b1;
            state_q    <= DONE;
          end else begin
            tries_q <= tries_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
